// File: rtl/rr_arb_slice_if.sv
// Handshake bundle between N requesters, the arbiter slice and one consumer.
// slave: arbiter side (payload/valid in, ready/beat out); master: environment.
interface rr_arb_slice_if #(
  parameter int N_INP = 4,
  parameter type t = logic
);
  localparam int IDX_W = $clog2(N_INP);

  t                   data_i [N_INP];
  logic [N_INP-1:0]   vld_i;
  logic [N_INP-1:0]   rdy_o;
  t                   data_o;
  logic [IDX_W-1:0]   idx_o;
  logic               vld_o;
  logic               rdy_i;

  modport slave (
    input  data_i, vld_i, rdy_i,
    output rdy_o, data_o, idx_o, vld_o
  );

  modport master (
    output data_i, vld_i, rdy_i,
    input  rdy_o, data_o, idx_o, vld_o
  );
endinterface

// File: rtl/rr_arb_slice.sv
// Round-robin arbiter feeding a single-entry registered valid/ready slice.
// Ports: clk_i, rst_ni (async low), clear_i (sync clear), bus (slave side).
module rr_arb_slice #(
  parameter int N_INP = 4,
  parameter type t = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  rr_arb_slice_if.slave bus
);
  localparam int IDX_W = $clog2(N_INP);

  typedef enum logic {EMPTY, FULL} st_e;

  st_e              st_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  t                 data_q;

  logic             can_acc;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [N_INP-1:0] gnt;
  logic [N_INP-1:0] rdy;
  logic             acc;

  // Refill is allowed in the same cycle the held beat drains.
  assign can_acc = (st_q == EMPTY) | bus.rdy_i;

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N_INP; k++) begin
      j = (int'(ptr_q) + k) % N_INP;
      if (!found && bus.vld_i[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[win] = 1'b1;
  end

  assign rdy = {N_INP{can_acc & ~clear_i}} & gnt;
  assign acc = |(bus.vld_i & rdy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= EMPTY;
      ptr_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (clear_i) begin
      st_q   <= EMPTY;
      ptr_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (acc) begin
      st_q   <= FULL;
      data_q <= bus.data_i[win];
      idx_q  <= win;
      ptr_q  <= (win == IDX_W'(N_INP - 1))
              ? '0 : win + IDX_W'(1);
    end else if (st_q == FULL && bus.rdy_i) begin
      st_q <= EMPTY;
    end
  end

  assign bus.rdy_o  = rdy;
  assign bus.vld_o  = (st_q == FULL);
  assign bus.data_o = data_q;
  assign bus.idx_o  = idx_q;
endmodule

// File: tb/tb_rr_arb_slice.sv
// Self-checking bench for rr_arb_slice: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_rr_arb_slice;
  localparam int N = 4;
  typedef logic [7:0] d_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  rr_arb_slice_if #(.N_INP(N), .t(d_t)) bus ();

  rr_arb_slice #(.N_INP(N), .t(d_t)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit m_full;
  d_t m_data;
  int m_idx;
  int m_ptr;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic        c;
    logic [3:0]  er;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  ei;
  } row_t;

  row_t tbl [9];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic [3:0] v, logic [31:0] d,
                       logic r, logic c);
    bus.vld_i = v;
    for (int i = 0; i < N; i++) bus.data_i[i] = d[8*i +: 8];
    bus.rdy_i = r;
    clr = c;
  endtask

  function automatic int m_win(logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_full = 0;
    m_data = '0;
    m_idx = 0;
    m_ptr = 0;
  endtask

  // One clock cycle: inputs already driven just after a posedge.
  task automatic cyc();
    int w;
    logic [N-1:0] er;
    bit can;
    @(negedge clk);
    chk("vld_o", 64'(bus.vld_o), 64'(m_full));
    chk("data_o", 64'(bus.data_o), 64'(m_data));
    chk("idx_o", 64'(bus.idx_o), 64'(m_idx));
    w = m_win(bus.vld_i);
    can = !m_full || bus.rdy_i;
    er = '0;
    if (can && !clr && w >= 0) er[w] = 1'b1;
    chk("rdy_o", 64'(bus.rdy_o), 64'(er));
    @(posedge clk);
    if (clr) m_reset();
    else if (er != 0) begin
      m_full = 1;
      m_data = bus.data_i[w];
      m_idx = w;
      m_ptr = (w + 1) % N;
    end else if (m_full && bus.rdy_i) m_full = 0;
    #1;
  endtask

  localparam logic [31:0] DALL = 32'h13121110;

  initial begin
    tbl[0] = '{4'b0100, 32'h00A50000, 1, 0, 4'b0100, 1, 8'hA5, 2'd2};
    tbl[1] = '{4'b1111, DALL, 1, 0, 4'b1000, 1, 8'h13, 2'd3};
    tbl[2] = '{4'b1111, DALL, 1, 0, 4'b0001, 1, 8'h10, 2'd0};
    tbl[3] = '{4'b1111, DALL, 1, 0, 4'b0010, 1, 8'h11, 2'd1};
    tbl[4] = '{4'b0000, DALL, 1, 0, 4'b0000, 0, 8'h11, 2'd1};
    tbl[5] = '{4'b1010, DALL, 0, 0, 4'b1000, 1, 8'h13, 2'd3};
    tbl[6] = '{4'b1010, DALL, 0, 0, 4'b0000, 1, 8'h13, 2'd3};
    tbl[7] = '{4'b1010, DALL, 1, 1, 4'b0000, 0, 8'h00, 2'd0};
    tbl[8] = '{4'b1010, DALL, 1, 0, 4'b0010, 1, 8'h11, 2'd1};

    drive(4'b1111, DALL, 1'b1, 1'b0);
    m_reset();
    #12;
    chk("rst_vld", 64'(bus.vld_o), 64'(0));
    chk("rst_data", 64'(bus.data_o), 64'(0));
    chk("rst_idx", 64'(bus.idx_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      #1;
      chk($sformatf("tbl%0d_rdy", i), 64'(bus.rdy_o), 64'(tbl[i].er));
      cyc();
      chk($sformatf("tbl%0d_vld", i), 64'(bus.vld_o), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 64'(bus.data_o), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_idx", i), 64'(bus.idx_o), 64'(tbl[i].ei));
    end

    // Stall while FULL with idx 0, then release
    drive(4'b0000, DALL, 1'b1, 1'b1);
    cyc();
    drive(4'b1111, DALL, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_idx", 64'(bus.idx_o), 64'(0));
      chk("stall_data", 64'(bus.data_o), 64'(8'h10));
    end
    drive(4'b1111, DALL, 1'b1, 1'b0);
    cyc();
    chk("release_idx", 64'(bus.idx_o), 64'(1));

    // Alternation between inputs 1 and 3, then 1 only
    drive(4'b1010, DALL, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt_idx", 64'(bus.idx_o), 64'((i % 2 == 0) ? 3 : 1));
    end
    drive(4'b0010, DALL, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("solo_idx", 64'(bus.idx_o), 64'(1));
    end

    // Fairness: all valid, 8 beats -> each input exactly twice
    begin
      int cnt [N];
      for (int i = 0; i < N; i++) cnt[i] = 0;
      drive(4'b1111, DALL, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
        cyc();
        cnt[bus.idx_o]++;
      end
      for (int i = 0; i < N; i++)
        chk($sformatf("fair%0d", i), 64'(cnt[i]), 64'(2));
    end

    // Async reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.vld_o), 64'(0));
    chk("arst_data", 64'(bus.data_o), 64'(0));
    chk("arst_idx", 64'(bus.idx_o), 64'(0));
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b1111, DALL, 1'b1, 1'b0);
    cyc();
    chk("post_rst_idx", 64'(bus.idx_o), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(4'($urandom), $urandom, 1'($urandom % 4 != 0),
            1'($urandom % 16 == 0));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
